// File: rtl/ssd_driver.sv
// ssd_driver: 13-bit binary value to a 4-digit common-anode seven-segment display.
// A sequential double-dabble engine converts a changed input into four BCD
// digits, which are then time-multiplexed onto the shared cathodes.
module ssd_driver #(
  parameter int unsigned REFRESH_BITS = 20,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] num,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [12:0]       shadow_q, shadow_d;
  logic [12:0]       shreg_q, shreg_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [15:0]       bcd_adj;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [15:0]       digits_q, digits_d;
  logic              busy_q, busy_d;

  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [1:0]        sel;
  logic [3:0]        blank;
  logic [3:0]        cur_digit;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        cathode_q, cathode_d;

  // Segment pattern {g..a}, active-low; out-of-range nibbles stay dark.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    bitcnt_d = bitcnt_q;
    digits_d = digits_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (num != shadow_q) begin
          shreg_d  = num;
          shadow_d = num;
          bcd_d    = '0;
          bitcnt_d = '0;
          busy_d   = 1'b1;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == 4'd12) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        digits_d = bcd_q;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Conversion state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      shreg_q  <= '0;
      bcd_q    <= '0;
      bitcnt_q <= '0;
      digits_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      bitcnt_q <= bitcnt_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
    end
  end

  // Scan selection, leading-zero blanking and the next pin values.
  always_comb begin
    refresh_d = refresh_q + CNT_ONE;
    sel       = refresh_q[REFRESH_BITS-1 -: 2];
    blank[3]  = BLANK_LZ && (digits_q[15:12] == 4'd0);
    blank[2]  = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1]  = blank[2] && (digits_q[7:4] == 4'd0);
    blank[0]  = 1'b0;
    cur_digit = digits_q[{sel, 2'b00} +: 4];
    anode_d   = ~(4'b0001 << sel);
    cathode_d = blank[sel] ? '1 : seg7(cur_digit);
  end

  // Refresh counter and registered display pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      anode_q   <= '1;
      cathode_q <= '1;
    end else begin
      refresh_q <= refresh_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;
  assign busy    = busy_q;

endmodule

// File: doc/ssd_driver.md
Name: ssd_driver

Overview:
- Receives the 13-bit `ssd` value that `RISCV_CPU` exports. Drives a 4-digit, common-anode seven-segment display on the FPGA board.
- Converts the binary value to 4 BCD digits with a sequential double-dabble engine, then time-multiplexes the digits onto shared cathodes.
- Sits at board top level, between `RISCV_CPU.ssd` and the display pins.

Parameters:
- REFRESH_BITS, 20, width of the free-running refresh counter. Its top 2 bits select the active digit. Bench uses 4.
- BLANK_LZ, 1, when 1, leading-zero digits are blanked. Digit 0 is never blanked.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- num  input  13  binary value to display (0..8191).
- anode  output  4  digit enables, active-low. anode[0] is the ones digit.
- cathode  output  7  segments, active-low. cathode[0]=a ... cathode[6]=g.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (async, active-high) forces:
  - anode=4'b1111, cathode=7'b1111111, busy=0
  - refresh counter=0, shadow=0, committed digits d3..d0=0, FSM=IDLE
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - If num != shadow: shift register <= num, shadow <= num, BCD accumulator <= 0, bit counter <= 0, busy <= 1, go to CONV.
  - Otherwise stay in IDLE.
- CONV, one step per cycle:
  - Each 4-bit BCD nibble >= 5 gets +3.
  - Then shift {bcd[15:0], shreg[12:0]} left by 1.
  - Bit counter increments. After the 13th shift, go to DONE.
- DONE:
  - d3..d0 <= BCD nibbles, busy <= 0, go to IDLE.
- Latency: num change sampled in IDLE at edge T → busy at T → committed digits at edge T+14 → visible on pins on the next scan of each digit, from T+15.
- num changes during CONV/DONE are ignored by the running conversion. On return to IDLE, num != shadow triggers a fresh conversion. Only the final stable value is guaranteed to be displayed.
- num held constant produces no further conversions (busy stays 0).
- Refresh counter:
  - Increments every cycle and wraps modulo 2^REFRESH_BITS.
  - sel = counter[REFRESH_BITS-1 -: 2].
- anode/cathode are registered, one cycle behind sel:
  - anode = ~(4'b0001 << sel).
  - cathode = segment pattern of d[sel], or 7'b1111111 if blanked.
- Blanking (BLANK_LZ=1): digit k (k=3,2,1) is blank iff d[k] and all higher digits are 0. d0 is always shown.
- Segment patterns, written {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Nibble values 10–15 cannot occur. Drive blank if they do.
- Reset mid-conversion: conversion is abandoned and all state returns to reset values. After release, the IDLE compare against shadow=0 restarts conversion if num != 0.
- Exactly one anode is low at any time after the first post-reset cycle.

Test Plan:
- Reset with num=0, release → busy never rises; scan shows anode 1110 with cathode 1000000, anodes 1101/1011/0111 with cathode 1111111. Each digit lasts 4 cycles at REFRESH_BITS=4.
- num=1234 → busy high for 14 cycles. Then d3..d0=1,2,3,4 and cathodes 1111001, 0100100, 0110000, 0011001 on anodes 0111, 1011, 1101, 1110.
- num=8191 (max) → digits 8,1,9,1. num=7 with BLANK_LZ=1 → only anode 1110 lit with 1111000. Same value with BLANK_LZ=0 → three leading 1000000 digits.
- num 1234 → 5678 two cycles after conversion starts → first result 1234 commits, immediately followed by a second conversion; final digits 5,6,7,8, busy total 28 cycles.
- Assert reset 5 cycles into converting 4321, release with num=4321 held → outputs at reset values during reset, then reconversion; final digits 4,3,2,1 with 1 busy period of 14 cycles.
- Refresh wrap: run 2^REFRESH_BITS+8 cycles → digit sequence 0,1,2,3 repeats without glitch, exactly one anode low every cycle.
